// File: rtl/eq_arb_ctrl_amisha.sv
// Round-robin arbiter feeding one shared 2-bit equality comparator.
// Each transaction walks IDLE -> LOAD -> COMPARE -> RESP and bumps a saturating match counter.
module eq_arb_ctrl_amisha (
   input  logic       clk_amisha,
   input  logic       rst_n_amisha,
   input  logic [3:0] req_amisha,
   input  logic [7:0] a_in_amisha,
   input  logic [7:0] b_in_amisha,
   input  logic       clr_cnt_amisha,
   output logic [3:0] gnt_amisha,
   output logic       busy_amisha,
   output logic       done_amisha,
   output logic       eq_amisha,
   output logic [1:0] id_amisha,
   output logic [3:0] match_cnt_amisha
);

   localparam int NUM_REQ = 4;
   localparam int VEC_W   = 2;
   localparam int ID_W    = 2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CMP, S_RESP} state_t;

   function automatic logic f_eq2(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
      return (a[1] ~^ b[1]) & (a[0] ~^ b[0]);
   endfunction

   state_t                        r_state, w_next;
   logic [NUM_REQ-1:0][VEC_W-1:0] w_a, w_b;
   logic [ID_W-1:0]               r_ptr, r_win, r_id, r_id_out;
   logic [ID_W-1:0]               w_win, w_idx;
   logic                          w_any;
   logic [VEC_W-1:0]              r_opa, r_opb;
   logic                          r_eq;
   logic [3:0]                    r_cnt;

   assign w_a = a_in_amisha;
   assign w_b = b_in_amisha;

   // Scan lowest priority first so the highest-priority hit (ptr+1) is written last.
   always_comb begin
      w_win = r_ptr;
      w_any = 1'b0;
      w_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_idx = r_ptr + ID_W'(k);
         if (req_amisha[w_idx]) begin
            w_win = w_idx;
            w_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha) r_state <= S_IDLE;
      else               r_state <= w_next;
   end

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = w_any ? S_LOAD : S_IDLE;
         S_LOAD:  w_next = S_CMP;
         S_CMP:   w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      gnt_amisha  = '0;
      busy_amisha = 1'b0;
      done_amisha = 1'b0;
      case (r_state)
         S_LOAD: begin
            gnt_amisha[r_win] = 1'b1;
            busy_amisha       = 1'b1;
         end
         S_CMP:  busy_amisha = 1'b1;
         S_RESP: begin
            busy_amisha = 1'b1;
            done_amisha = 1'b1;
         end
         default: ;
      endcase
   end

   // Winner is latched in IDLE so request changes later in the transaction are ignored.
   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha) begin
         r_win    <= '0;
         r_ptr    <= 2'd3;
         r_id     <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_eq     <= 1'b0;
         r_id_out <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_any) r_win <= w_win;
            S_LOAD: begin
               r_ptr <= r_win;
               r_id  <= r_win;
               r_opa <= w_a[r_win];
               r_opb <= w_b[r_win];
            end
            S_CMP: begin
               r_eq     <= f_eq2(r_opa, r_opb);
               r_id_out <= r_id;
            end
            default: ;
         endcase
      end
   end

   // Clear takes priority over a same-cycle increment.
   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha)
         r_cnt <= '0;
      else if (clr_cnt_amisha)
         r_cnt <= '0;
      else if (r_state == S_RESP && r_eq && r_cnt != 4'hF)
         r_cnt <= r_cnt + 4'd1;
   end

   assign eq_amisha        = r_eq;
   assign id_amisha        = r_id_out;
   assign match_cnt_amisha = r_cnt;

endmodule

// File: tb/tb_eq_arb_ctrl_amisha.sv
// Scoreboard bench: expected grant/id/eq pushed at stimulus time, popped when done pulses.
module tb_eq_arb_ctrl_amisha;

   logic       clk_amisha = 1'b0;
   logic       rst_n_amisha;
   logic [3:0] req_amisha;
   logic [7:0] a_in_amisha, b_in_amisha;
   logic       clr_cnt_amisha;
   logic [3:0] gnt_amisha;
   logic       busy_amisha, done_amisha, eq_amisha;
   logic [1:0] id_amisha;
   logic [3:0] match_cnt_amisha;

   always #5 clk_amisha = ~clk_amisha;

   eq_arb_ctrl_amisha dut (
      .clk_amisha       (clk_amisha),
      .rst_n_amisha     (rst_n_amisha),
      .req_amisha       (req_amisha),
      .a_in_amisha      (a_in_amisha),
      .b_in_amisha      (b_in_amisha),
      .clr_cnt_amisha   (clr_cnt_amisha),
      .gnt_amisha       (gnt_amisha),
      .busy_amisha      (busy_amisha),
      .done_amisha      (done_amisha),
      .eq_amisha        (eq_amisha),
      .id_amisha        (id_amisha),
      .match_cnt_amisha (match_cnt_amisha)
   );

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] id;
      logic       eq;
   } exp_t;

   exp_t       exp_q[$];
   int         n_chk = 0, n_pass = 0;
   int         cyc = 0, t_gnt = 0, t_done = 0;
   bit         spc_chk = 1'b0, have_done = 1'b0;
   logic [1:0] m_ptr = 2'd3;
   int         m_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      int idx;
      for (int k = 1; k <= 4; k++) begin
         idx = (int'(ptr) + k) % 4;
         if (req[idx]) return 2'(idx);
      end
      return ptr;
   endfunction

   task automatic push_exp(input logic [3:0] req, input logic [7:0] a, input logic [7:0] b);
      exp_t       e;
      logic [1:0] w;
      int         wi;
      w     = rr_pick(req, m_ptr);
      wi    = int'(w);
      m_ptr = w;
      e.gnt = 4'b0001 << wi;
      e.id  = w;
      e.eq  = (a[2*wi +: 2] == b[2*wi +: 2]);
      if (e.eq && m_cnt < 15) m_cnt++;
      exp_q.push_back(e);
   endtask

   // Every wait goes through here, so the output monitor runs on each falling edge.
   task automatic tick();
      exp_t e;
      @(negedge clk_amisha);
      cyc++;
      if (rst_n_amisha) begin
         if (gnt_amisha != 4'b0) begin
            if (exp_q.size() == 0) chk("gnt_unexp", 32'(gnt_amisha), 0);
            else                   chk("gnt", 32'(gnt_amisha), 32'(exp_q[0].gnt));
            t_gnt = cyc;
         end
         if (done_amisha) begin
            if (exp_q.size() == 0) chk("done_unexp", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("id", 32'(id_amisha), 32'(e.id));
               chk("eq", 32'(eq_amisha), 32'(e.eq));
               chk("gnt2done", cyc - t_gnt, 2);
               if (spc_chk && have_done) chk("done_spacing", cyc - t_done, 4);
               t_done    = cyc;
               have_done = 1'b1;
            end
         end
      end
   endtask

   task automatic wait_gnt();
      for (int i = 0; i < 12; i++) begin
         tick();
         if (gnt_amisha != 4'b0) return;
      end
      chk("gnt_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 12; i++) begin
         tick();
         if (!busy_amisha) return;
      end
      chk("idle_timeout", 0, 1);
   endtask

   task automatic txn(input logic [3:0] req, input logic [7:0] a, input logic [7:0] b);
      int c0;
      tick();
      req_amisha  = req;
      a_in_amisha = a;
      b_in_amisha = b;
      push_exp(req, a, b);
      c0 = cyc;
      wait_gnt();
      chk("req2gnt", t_gnt - c0, 1);
      tick();
      req_amisha = 4'b0;
      wait_idle();
   endtask

   task automatic do_reset();
      rst_n_amisha = 1'b0;
      exp_q.delete();
      m_ptr     = 2'd3;
      m_cnt     = 0;
      have_done = 1'b0;
      tick();
      tick();
      rst_n_amisha = 1'b1;
   endtask

   initial begin
      logic [7:0] av, bv;
      int         nd, c1;
      rst_n_amisha   = 1'b0;
      req_amisha     = 4'b0;
      a_in_amisha    = 8'h00;
      b_in_amisha    = 8'h00;
      clr_cnt_amisha = 1'b0;
      #2;
      chk("reset_outs", 32'({gnt_amisha, busy_amisha, done_amisha, eq_amisha, id_amisha, match_cnt_amisha}), 0);
      do_reset();

      // single request, requester 0, A=B=2
      txn(4'b0001, 8'h02, 8'h02);
      chk("single_cnt", 32'(match_cnt_amisha), 1);

      // all 16 operand pairs on requester 2, other lanes random
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            av[5:4] = 2'(a);
            bv[5:4] = 2'(b);
            txn(4'b0100, av, bv);
         end
      chk("exh_cnt", 32'(match_cnt_amisha), 32'(m_cnt));
      for (int i = 0; i < 16; i++) begin
         av = 8'($urandom);
         txn(4'b0100, av, av);
      end
      chk("sat_cnt", 32'(match_cnt_amisha), 15);

      // plain clear, then clear colliding with an eq=1 increment at count 5
      tick();
      clr_cnt_amisha = 1'b1;
      tick();
      clr_cnt_amisha = 1'b0;
      chk("clr_cnt", 32'(match_cnt_amisha), 0);
      m_cnt = 0;
      for (int i = 0; i < 5; i++) txn(4'b0010, 8'h0C, 8'h0C);
      chk("cnt_five", 32'(match_cnt_amisha), 5);
      tick();
      req_amisha  = 4'b0010;
      a_in_amisha = 8'hFF;
      b_in_amisha = 8'hFF;
      push_exp(4'b0010, 8'hFF, 8'hFF);
      wait_gnt();
      tick();
      req_amisha = 4'b0;
      tick();
      chk("col_in_resp", 32'(done_amisha), 1);
      clr_cnt_amisha = 1'b1;
      tick();
      clr_cnt_amisha = 1'b0;
      chk("clr_collision", 32'(match_cnt_amisha), 0);
      m_cnt = 0;
      wait_idle();

      // requester 3 raises req while requester 0 is in COMPARE
      tick();
      req_amisha  = 4'b0001;
      a_in_amisha = 8'h01;
      b_in_amisha = 8'h01;
      push_exp(4'b0001, 8'h01, 8'h01);
      wait_gnt();
      c1 = t_gnt;
      tick();
      req_amisha  = 4'b1000;
      a_in_amisha = 8'h81;
      b_in_amisha = 8'h41;
      push_exp(4'b1000, 8'h81, 8'h41);
      wait_gnt();
      chk("midbusy_gap", t_gnt - c1, 4);
      tick();
      req_amisha = 4'b0;
      wait_idle();
      chk("midbusy_cnt", 32'(match_cnt_amisha), 32'(m_cnt));

      // all four requesting continuously after reset
      do_reset();
      spc_chk = 1'b1;
      tick();
      req_amisha  = 4'b1111;
      a_in_amisha = 8'b11_10_01_00;
      b_in_amisha = 8'b11_00_01_11;
      for (int i = 0; i < 5; i++) push_exp(4'b1111, a_in_amisha, b_in_amisha);
      nd = 0;
      for (int i = 0; i < 40 && nd < 5; i++) begin
         tick();
         if (done_amisha) nd++;
      end
      req_amisha = 4'b0;
      chk("rr_dones", nd, 5);
      wait_idle();
      spc_chk = 1'b0;
      chk("rr_cnt", 32'(match_cnt_amisha), 32'(m_cnt));

      // reset during COMPARE aborts the transaction
      tick();
      req_amisha  = 4'b0001;
      a_in_amisha = 8'h01;
      b_in_amisha = 8'h01;
      push_exp(4'b0001, 8'h01, 8'h01);
      wait_gnt();
      tick();
      rst_n_amisha = 1'b0;
      #1;
      chk("abort_outs", 32'({gnt_amisha, busy_amisha, done_amisha, eq_amisha, id_amisha, match_cnt_amisha}), 0);
      exp_q.delete();
      m_ptr      = 2'd3;
      m_cnt      = 0;
      have_done  = 1'b0;
      req_amisha = 4'b0;
      tick();
      tick();
      rst_n_amisha = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("abort_cnt", 32'(match_cnt_amisha), 0);
      txn(4'b0001, 8'h03, 8'h03);
      chk("post_abort_cnt", 32'(match_cnt_amisha), 1);

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/eq_arb_ctrl_amisha.md
EQ_ARB_CTRL_AMISHA -- requirements
Module: eq_arb_ctrl_amisha

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_amisha  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n_amisha  input  1  asynchronous active-low reset.
REQ-004 req_amisha  input  4  per-requester compare request; bit i = requester i.
REQ-005 a_in_amisha  input  8  operand A; bits [2i+1:2i] belong to requester i.
REQ-006 b_in_amisha  input  8  operand B; bits [2i+1:2i] belong to requester i.
REQ-007 clr_cnt_amisha  input  1  synchronous clear of match counter.
REQ-008 gnt_amisha  output  4  one-hot grant pulse; operands captured this cycle.
REQ-009 busy_amisha  output  1  high in every state except IDLE.
REQ-010 done_amisha  output  1  one-cycle result-valid pulse.
REQ-011 eq_amisha  output  1  comparison result (1 = A equals B); valid when done_amisha=1.
REQ-012 id_amisha  output  2  index of the requester whose result is on eq_amisha.
REQ-013 match_cnt_amisha  output  4  saturating count of completed compares with eq=1.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, COMPARE and RESP, and no others reachable.
REQ-015 IDLE: if req_amisha != 0, go to LOAD; else stay in IDLE.
REQ-016 Arbitration SHALL be round-robin from last-granted pointer ptr (2 bits): priority order ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-017 Arbitration SHALL use req_amisha sampled in IDLE only; request changes in other states do not affect the current transaction.
REQ-018 LOAD: gnt_amisha SHALL be one-hot for the winner for exactly one cycle; the winner's 2-bit A and B SHALL be registered; ptr and the id register SHALL be updated to the winner; go to COMPARE.
REQ-019 COMPARE: a shared 2-bit equality function SHALL evaluate the registered operands (eq = A[1]~^B[1] & A[0]~^B[0], correct for all 16 combinations); the result SHALL be registered; go to RESP.
REQ-020 RESP: done_amisha=1 for one cycle with eq_amisha and id_amisha valid; go to IDLE.
REQ-021 Latency: gnt pulse to done pulse SHALL be exactly 2 cycles; a request seen in IDLE SHALL be granted on the next cycle.
REQ-022 Minimum transaction spacing SHALL be 4 cycles (IDLE, LOAD, COMPARE, RESP); back-to-back requests are served with no extra idle cycles.
REQ-023 A requester SHALL hold req and operands until its gnt pulse; a req still high in the IDLE following RESP counts as a new request.
REQ-024 eq_amisha and id_amisha SHALL hold their last values outside RESP; gnt_amisha SHALL be 0 outside LOAD.
REQ-025 match_cnt_amisha SHALL increment by 1 in RESP when eq=1 and saturate at 15 (no wrap).
REQ-026 clr_cnt_amisha=1 SHALL zero the counter on the next edge; clear wins over a simultaneous increment.
REQ-027 Unreachable state encodings SHALL return to IDLE on the next edge with no outputs asserted.

Reset
REQ-028 While rst_n_amisha=0: state=IDLE, ptr=3 (requester 0 highest priority first), gnt=0, busy=0, done=0, eq=0, id=0, match_cnt=0, operand registers=0.
REQ-029 Reset asserted mid-transaction SHALL abort it immediately; no done pulse and no counter update occur for the aborted request.
REQ-030 After reset release, the first active edge SHALL evaluate arbitration from IDLE.

Verification
REQ-031 Single request: req=0001, A[1:0]=2, B[1:0]=2 -> gnt=0001 at cycle 1, done=1, eq=1, id=0 at cycle 3; match_cnt=1.
REQ-032 Exhaustive compare: requester 2 with all 16 (A,B) pairs -> eq=1 only for A==B; match_cnt saturates at 15 after 16 sequential passes of A==B cases.
REQ-033 Round-robin: req=1111 held continuously after reset -> grant order 0,1,2,3,0 with done pulses exactly 4 cycles apart.
REQ-034 Mid-busy request: req=0001 granted, req=1000 raised during COMPARE -> requester 3 granted in the LOAD following the next IDLE; requester 0 transaction unaffected.
REQ-035 Reset abort: rst_n_amisha low during COMPARE -> all outputs 0 asynchronously, no done pulse, match_cnt=0; next request after release is served normally.
REQ-036 Clear collision: clr_cnt_amisha=1 in the RESP cycle of an eq=1 compare with match_cnt=5 -> match_cnt=0.
